// File: rtl/falling_edge_generator_if.sv
// rtl/falling_edge_generator_if.sv - start/abort request and line/status bundle for the falling-edge generator
interface falling_edge_generator_if #(
   parameter int CNT_W = 8
);
   logic             start;
   logic [CNT_W-1:0] num_edges;
   logic             abort;
   logic             ready;
   logic             busy;
   logic             line_out;
   logic             edge_strobe;
   logic             done;

   modport master (
      output start, num_edges, abort,
      input  ready, busy, line_out, edge_strobe, done
   );

   modport slave (
      input  start, num_edges, abort,
      output ready, busy, line_out, edge_strobe, done
   );
endinterface

// File: rtl/falling_edge_generator.sv
// rtl/falling_edge_generator.sv - drives a burst of falling edges with programmable high/low hold times
module falling_edge_generator #(
   parameter int HIGH_CYCLES = 4,
   parameter int LOW_CYCLES  = 4,
   parameter int CNT_W       = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   falling_edge_generator_if.slave  bus
);
   localparam int MAX_HOLD = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
   localparam int TW       = $clog2(MAX_HOLD + 1);
   localparam logic [TW-1:0] H_LOAD = TW'(HIGH_CYCLES - 1);
   localparam logic [TW-1:0] L_LOAD = TW'(LOW_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] rem_q;
   logic [TW-1:0]    tmr_q;
   logic             line_q;
   logic             strobe_q;
   logic             done_q;
   logic             busy_q;

   // The timer counts down from hold-1 so expiry is simply tmr_q == 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         rem_q    <= '0;
         tmr_q    <= '0;
         line_q   <= 1'b0;
         strobe_q <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         strobe_q <= 1'b0;
         done_q   <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (bus.start && (bus.num_edges != '0)) begin
                  state_q <= ST_HIGH;
                  rem_q   <= bus.num_edges;
                  tmr_q   <= H_LOAD;
                  line_q  <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            ST_HIGH: begin
               if (bus.abort) begin
                  // Dropping the line from high is a genuine edge, so echo it.
                  state_q  <= ST_IDLE;
                  rem_q    <= '0;
                  tmr_q    <= '0;
                  line_q   <= 1'b0;
                  strobe_q <= 1'b1;
                  busy_q   <= 1'b0;
               end else if (tmr_q == '0) begin
                  state_q  <= ST_LOW;
                  rem_q    <= rem_q - CNT_W'(1);
                  tmr_q    <= L_LOAD;
                  line_q   <= 1'b0;
                  strobe_q <= 1'b1;
               end else begin
                  tmr_q <= tmr_q - TW'(1);
               end
            end
            ST_LOW: begin
               if (bus.abort) begin
                  state_q <= ST_IDLE;
                  rem_q   <= '0;
                  tmr_q   <= '0;
                  busy_q  <= 1'b0;
               end else if (tmr_q == '0) begin
                  if (rem_q == '0) begin
                     state_q <= ST_IDLE;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= ST_HIGH;
                     tmr_q   <= H_LOAD;
                     line_q  <= 1'b1;
                  end
               end else begin
                  tmr_q <= tmr_q - TW'(1);
               end
            end
            default: begin
               state_q <= ST_IDLE;
               rem_q   <= '0;
               tmr_q   <= '0;
               line_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ready       = (state_q == ST_IDLE);
   assign bus.busy        = busy_q;
   assign bus.line_out    = line_q;
   assign bus.edge_strobe = strobe_q;
   assign bus.done        = done_q;
endmodule
